// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encodings, reset level and default
// address constants for the PC sequencer and its phase counter.
package pc_sequencer_pkg;

    // Instruction sequencing states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    // Asserted level of the asynchronous reset input.
    localparam logic RST_VAL = 1'b0;

    // Default PC after reset and default sequential increment.
    localparam logic [31:0]    DEF_RESET_VECTOR = 32'h8000_0000;
    localparam int unsigned    DEF_PC_INC       = 4;

    // Width needed to index EXEC phases; never narrower than one bit.
    function automatic int unsigned phase_width(input int unsigned phases);
        return (phases > 1) ? $clog2(phases) : 1;
    endfunction

endpackage

// File: rtl/pc_sequencer_phase_counter.sv
// phase_counter: counts EXEC phases 0..EXEC_PHASES-1. 'start' clears the
// count ahead of a new EXEC run, 'enable' advances it, and 'last' flags the
// final phase so the sequencer can leave EXEC.
module phase_counter
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned EXEC_PHASES = 1,
    parameter int unsigned PHASE_W     = phase_width(EXEC_PHASES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               enable,
    output logic [PHASE_W-1:0] phase,
    output logic               last
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(EXEC_PHASES - 1);

    // Phase register: cleared on start, advanced while enabled, wraps after the last phase.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_VAL) begin
            phase <= '0;
        end else if (start) begin
            phase <= '0;
        end else if (enable) begin
            phase <= last ? '0 : phase + PHASE_W'(1);
        end
    end

    // Final-phase flag.
    always_comb begin
        last = (phase == LAST_PHASE);
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC and sequences BOOT -> FETCH -> EXEC(N) -> WB,
// with a valid handshake to instruction memory, taken-branch redirect in WB
// and an absorbing HALT state. All outputs are decoded from registered state.
// Optional feature macro: RETIRE_CNT_EN enables the 64-bit retire counter;
// without it retire_cnt is tied to zero.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter int unsigned     PC_INC       = DEF_PC_INC,
    parameter int unsigned     EXEC_PHASES  = 1,
    parameter int unsigned     PHASE_W      = phase_width(EXEC_PHASES)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ifu_req,
    output logic [XLEN-1:0]    ifu_addr,
    input  logic               ifu_valid,
    input  logic [31:0]        ifu_inst,
    output logic [31:0]        inst,
    output logic               exec_active,
    output logic [PHASE_W-1:0] exec_phase,
    output logic               wb_en,
    input  logic               redirect_en,
    input  logic [XLEN-1:0]    redirect_target,
    input  logic               halt_req,
    output logic               halted,
    output logic [XLEN-1:0]    pc,
    output logic [63:0]        retire_cnt
);

    state_t            state_q;
    state_t            state_d;
    logic [XLEN-1:0]   pc_q;
    logic [31:0]       inst_q;
    logic [PHASE_W-1:0] phase;
    logic              phase_last;
    logic              fetch_accept;
    logic              in_exec;
    logic              in_wb;
    logic [XLEN-1:0]   pc_next;

    // Redirect targets are forced word-aligned, so the low two bits never matter.
    logic [1:0]        unused_target_lsbs;
    assign unused_target_lsbs = redirect_target[1:0];

    assign fetch_accept = (state_q == ST_FETCH) && ifu_valid;
    assign in_exec      = (state_q == ST_EXEC);
    assign in_wb        = (state_q == ST_WB);

    phase_counter #(
        .EXEC_PHASES (EXEC_PHASES),
        .PHASE_W     (PHASE_W)
    ) u_phase_counter (
        .clk    (clk),
        .rst    (rst),
        .start  (fetch_accept),
        .enable (in_exec),
        .phase  (phase),
        .last   (phase_last)
    );

    // State register; reset aborts any fetch or EXEC in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_VAL) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: if (ifu_valid) state_d = ST_EXEC;
            ST_EXEC:  if (phase_last) state_d = ST_WB;
            ST_WB:    state_d = halt_req ? ST_HALT : ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_BOOT;
        endcase
    end

    // Successor PC: aligned redirect target or sequential step (wraps naturally).
    always_comb begin
        pc_next = pc_q + XLEN'(PC_INC);
        if (redirect_en) begin
            pc_next = {redirect_target[XLEN-1:2], 2'b00};
        end
    end

    // PC register updates only at the end of WB, including the WB that halts.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_VAL) begin
            pc_q <= RESET_VECTOR;
        end else if (in_wb) begin
            pc_q <= pc_next;
        end
    end

    // Instruction register captures the fetched word on handshake only.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_VAL) begin
            inst_q <= '0;
        end else if (fetch_accept) begin
            inst_q <= ifu_inst;
        end
    end

    // Moore output decode from registered state.
    always_comb begin
        ifu_req     = 1'b0;
        exec_active = 1'b0;
        wb_en       = 1'b0;
        halted      = 1'b0;
        exec_phase  = '0;
        case (state_q)
            ST_FETCH: ifu_req = 1'b1;
            ST_EXEC: begin
                exec_active = 1'b1;
                exec_phase  = phase;
            end
            ST_WB:    wb_en  = 1'b1;
            ST_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign ifu_addr = pc_q;
    assign pc       = pc_q;
    assign inst     = inst_q;

`ifdef RETIRE_CNT_EN
    logic [63:0] retire_q;

    // Retired-instruction counter, one increment per WB, wraps at 2^64.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_VAL) begin
            retire_q <= '0;
        end else if (in_wb) begin
            retire_q <= retire_q + 64'd1;
        end
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed, table-driven checks of pc_sequencer with
// EXEC_PHASES=1 (dut1) and EXEC_PHASES=4 (dut4) sharing clock and reset.
module tb_pc_sequencer;

`ifdef RETIRE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    // dut1 signals
    logic        valid1 = 1'b0;
    logic [31:0] iin1   = '0;
    logic        redir1 = 1'b0;
    logic [31:0] tgt1   = '0;
    logic        halt1  = 1'b0;
    logic        req1, exec1, wb1, halted1;
    logic [31:0] addr1, inst1, pc1;
    logic [0:0]  phase1;
    logic [63:0] rcnt1;

    // dut4 signals
    logic        valid4 = 1'b0;
    logic [31:0] iin4   = '0;
    logic        req4, exec4, wb4, halted4;
    logic [31:0] addr4, inst4, pc4;
    logic [1:0]  phase4;
    logic [63:0] rcnt4;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.EXEC_PHASES(1)) dut1 (
        .clk(clk), .rst(rst), .ifu_req(req1), .ifu_addr(addr1), .ifu_valid(valid1),
        .ifu_inst(iin1), .inst(inst1), .exec_active(exec1), .exec_phase(phase1),
        .wb_en(wb1), .redirect_en(redir1), .redirect_target(tgt1), .halt_req(halt1),
        .halted(halted1), .pc(pc1), .retire_cnt(rcnt1)
    );

    pc_sequencer #(.EXEC_PHASES(4)) dut4 (
        .clk(clk), .rst(rst), .ifu_req(req4), .ifu_addr(addr4), .ifu_valid(valid4),
        .ifu_inst(iin4), .inst(inst4), .exec_active(exec4), .exec_phase(phase4),
        .wb_en(wb4), .redirect_en(1'b0), .redirect_target(32'h0), .halt_req(1'b0),
        .halted(halted4), .pc(pc4), .retire_cnt(rcnt4)
    );

    typedef struct {
        int unsigned delay;
        logic [31:0] iword;
        logic        redir;
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
        logic        noise;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    initial begin
        vecs[0] = '{0, 32'h00500093, 1'b0, 32'h0,         32'h8000_0000, 32'h8000_0004, 1'b0};
        vecs[1] = '{2, 32'h00108113, 1'b1, 32'h8000_0102, 32'h8000_0004, 32'h8000_0100, 1'b0};
        vecs[2] = '{0, 32'h12345678, 1'b0, 32'h0,         32'h8000_0100, 32'h8000_0104, 1'b1};
        vecs[3] = '{1, 32'h0000006f, 1'b1, 32'hFFFF_FFFE, 32'h8000_0104, 32'hFFFF_FFFC, 1'b0};
        vecs[4] = '{0, 32'h00000013, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
        vecs[5] = '{0, 32'hDEADBEEF, 1'b1, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[6] = '{3, 32'h00A00513, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004, 1'b0};
        vecs[7] = '{0, 32'h0BADF00D, 1'b1, 32'h8000_0000, 32'h0000_0004, 32'h8000_0000, 1'b0};
        vecs[8] = '{0, 32'h00000073, 1'b0, 32'h0,         32'h8000_0000, 32'h8000_0004, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_pc1",     64'(pc1),     64'h8000_0000);
        chk("rst_req1",    64'(req1),    64'h0);
        chk("rst_wb1",     64'(wb1),     64'h0);
        chk("rst_exec1",   64'(exec1),   64'h0);
        chk("rst_halted1", 64'(halted1), 64'h0);
        chk("rst_inst1",   64'(inst1),   64'h0);
        chk("rst_rcnt1",   rcnt1,        64'h0);
        chk("rst_phase4",  64'(phase4),  64'h0);

        // Release: one BOOT cycle, then FETCH
        rst = 1'b1;
        chk("boot_req1", 64'(req1), 64'h0);
        chk("boot_req4", 64'(req4), 64'h0);
        tick();
        chk("fetch_req1",  64'(req1),  64'h1);
        chk("fetch_addr1", 64'(addr1), 64'h8000_0000);
        chk("fetch_req4",  64'(req4),  64'h1);

        // dut4: fetch delayed 3 cycles, then 4 EXEC phases, WB, next FETCH
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("d4_wait_req",  64'(req4),  64'h1);
            chk("d4_wait_addr", 64'(addr4), 64'h8000_0000);
        end
        valid4 = 1'b1;
        iin4   = 32'h00500093;
        tick();
        valid4 = 1'b0;
        iin4   = 32'hFFFF_FFFF;
        for (int p = 0; p < 4; p++) begin
            chk("d4_exec_active", 64'(exec4),  64'h1);
            chk("d4_exec_phase",  64'(phase4), 64'(p));
            chk("d4_exec_inst",   64'(inst4),  64'h00500093);
            chk("d4_exec_wb",     64'(wb4),    64'h0);
            tick();
        end
        chk("d4_wb_en",    64'(wb4),    64'h1);
        chk("d4_wb_inst",  64'(inst4),  64'h00500093);
        chk("d4_wb_phase", 64'(phase4), 64'h0);
        chk("d4_wb_exec",  64'(exec4),  64'h0);
        tick();
        chk("d4_next_wb",   64'(wb4),   64'h0);
        chk("d4_next_req",  64'(req4),  64'h1);
        chk("d4_next_addr", 64'(addr4), 64'h8000_0004);
        chk("d4_rcnt",      rcnt4,      CNT_ON ? 64'd1 : 64'd0);

        // dut1: table of instructions
        foreach (vecs[k]) begin
            chk("tbl_req",  64'(req1),  64'h1);
            chk("tbl_addr", 64'(addr1), 64'(vecs[k].exp_addr));
            for (int d = 0; d < int'(vecs[k].delay); d++) begin
                tick();
                chk("tbl_wait_req",  64'(req1),  64'h1);
                chk("tbl_wait_addr", 64'(addr1), 64'(vecs[k].exp_addr));
            end
            valid1 = 1'b1;
            iin1   = vecs[k].iword;
            tick();
            chk("tbl_exec",      64'(exec1), 64'h1);
            chk("tbl_exec_inst", 64'(inst1), 64'(vecs[k].iword));
            chk("tbl_exec_req",  64'(req1),  64'h0);
            if (vecs[k].noise) begin
                iin1   = ~vecs[k].iword;
                redir1 = 1'b1;
                tgt1   = 32'h0000_1000;
            end else begin
                valid1 = 1'b0;
            end
            tick();
            chk("tbl_wb",      64'(wb1),   64'h1);
            chk("tbl_wb_inst", 64'(inst1), 64'(vecs[k].iword));
            valid1 = 1'b0;
            redir1 = vecs[k].redir;
            tgt1   = vecs[k].target;
            tick();
            redir1 = 1'b0;
            chk("tbl_post_wb", 64'(wb1), 64'h0);
            chk("tbl_next_pc", 64'(pc1), 64'(vecs[k].exp_next));
        end

        // dut1: halting instruction with simultaneous redirect
        chk("halt_addr", 64'(addr1), 64'h8000_0004);
        valid1 = 1'b1;
        iin1   = 32'h00100073;
        tick();
        valid1 = 1'b0;
        tick();
        chk("halt_wb", 64'(wb1), 64'h1);
        halt1  = 1'b1;
        redir1 = 1'b1;
        tgt1   = 32'h8000_0201;
        tick();
        halt1  = 1'b0;
        redir1 = 1'b0;
        valid1 = 1'b1;
        chk("halted",      64'(halted1), 64'h1);
        chk("halted_pc",   64'(pc1),     64'h8000_0200);
        chk("halted_req",  64'(req1),    64'h0);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("halt_hold",     64'(halted1), 64'h1);
            chk("halt_hold_req", 64'(req1),    64'h0);
            chk("halt_hold_wb",  64'(wb1),     64'h0);
            chk("halt_hold_pc",  64'(pc1),     64'h8000_0200);
        end
        valid1 = 1'b0;
        chk("retire_cnt", rcnt1, CNT_ON ? 64'd10 : 64'd0);

        // Asynchronous reset mid-FETCH (dut4) / in HALT (dut1)
        #3;
        rst = 1'b0;
        #1;
        chk("arst_f_req4",    64'(req4),    64'h0);
        chk("arst_f_pc4",     64'(pc4),     64'h8000_0000);
        chk("arst_f_halted1", 64'(halted1), 64'h0);
        chk("arst_f_pc1",     64'(pc1),     64'h8000_0000);
        chk("arst_f_rcnt1",   rcnt1,        64'h0);
        tick();
        rst = 1'b1;
        chk("arst_boot_req4", 64'(req4), 64'h0);
        tick();
        chk("arst_fetch_req4",  64'(req4),  64'h1);
        chk("arst_fetch_addr4", 64'(addr4), 64'h8000_0000);

        // Asynchronous reset mid-EXEC (dut4)
        valid4 = 1'b1;
        iin4   = 32'h00208233;
        tick();
        valid4 = 1'b0;
        tick();
        chk("pre_arst_phase4", 64'(phase4), 64'h1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_e_exec4",  64'(exec4),  64'h0);
        chk("arst_e_phase4", 64'(phase4), 64'h0);
        chk("arst_e_pc4",    64'(pc4),    64'h8000_0000);
        chk("arst_e_inst4",  64'(inst4),  64'h0);
        chk("arst_e_req4",   64'(req4),   64'h0);
        tick();
        rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised successor to the fixed 3-phase counter/PC pair. Owns the PC and the multi-cycle instruction sequence BOOT -> FETCH -> EXEC(N phases) -> WB, with a valid handshake to instruction memory, taken-branch redirect, and halt.
Sits between the IFU/instruction memory and the decode/regfile/ALU datapath, driving the regfile write strobe and the latched instruction.

Parameters:
XLEN, 32, PC/address width
RESET_VECTOR, 32'h8000_0000, PC value after reset
PC_INC, 4, sequential PC increment
EXEC_PHASES, 1, EXEC cycles per instruction (>=1)
PHASE_W, max(1,$clog2(EXEC_PHASES)), width of exec_phase (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
ifu_req  out  1  fetch request, high only in FETCH
ifu_addr  out  XLEN  fetch address, equals pc
ifu_valid  in  1  fetch data valid; sampled only while ifu_req=1
ifu_inst  in  32  fetched instruction
inst  out  32  latched instruction register
exec_active  out  1  high in EXEC
exec_phase  out  PHASE_W  current EXEC phase index; 0 outside EXEC
wb_en  out  1  one-cycle regfile write strobe, high in WB
redirect_en  in  1  taken branch/jump; sampled only in WB
redirect_target  in  XLEN  next PC when redirect_en=1
halt_req  in  1  stop after this instruction; sampled only in WB
halted  out  1  high in HALT
pc  out  XLEN  current PC
retire_cnt  out  64  retired-instruction count (see Optional Feature)

Behaviour:
- States: BOOT, FETCH, EXEC, WB, HALT. All outputs are Moore, decoded from registered state.
- Reset (rst=0, asynchronous): state=BOOT, pc=RESET_VECTOR, inst=0, phase=0, retire_cnt=0. All strobes are 0. A reset mid-operation aborts any fetch or EXEC immediately.
- BOOT: one cycle after reset release, then FETCH. ifu_req=0.
- FETCH: ifu_req=1, ifu_addr=pc held stable. Waits indefinitely for ifu_valid. On ifu_valid=1: inst<=ifu_inst, phase<=0, go to EXEC. ifu_valid in any other state is ignored.
- EXEC: exec_active=1, exec_phase counts 0..EXEC_PHASES-1, one per cycle. At phase EXEC_PHASES-1, go to WB. With EXEC_PHASES=1, EXEC lasts exactly one cycle.
- WB: wb_en=1 for exactly one cycle. At the end of WB:
  - pc <= redirect_en ? {redirect_target[XLEN-1:2],2'b00} : pc+PC_INC. The sum wraps modulo 2^XLEN.
  - retire_cnt increments.
  - If halt_req=1, go to HALT (the pc update still occurs); otherwise go to FETCH.
  - redirect_en and halt_req asserted together: both take effect.
- HALT: absorbing until reset. halted=1, ifu_req=0, wb_en=0, pc frozen.
- Latency: an instruction takes (fetch wait, >=1) + EXEC_PHASES + 1 cycles. With EXEC_PHASES=1 and ifu_valid in the first FETCH cycle, this is 3 cycles, the same rhythm as the previous generation.
- inst is stable from the cycle after fetch acceptance through the end of WB.

Optional Feature:
RETIRE_CNT_EN
- Defined: 64-bit retire_cnt increments once per WB, wraps at 2^64, and is reset to 0.
- Undefined: the retire_cnt port remains and is tied to 0; no counter flops are synthesised.

Decomposition:
- Shared defines file: state encodings (BOOT/FETCH/EXEC/WB/HALT, 3-bit), RST_VAL for the active-low level, default RESET_VECTOR, PC_INC.
- One sub-module: phase_counter. Inputs: clk, rst, start, enable. Outputs: phase, last. Parametrised by EXEC_PHASES.

Test Plan:
- Reset release, ifu_valid tied 1, EXEC_PHASES=1 -> ifu_addr 8000_0000, 8000_0004, 8000_0008 on successive FETCH cycles 3 clocks apart; wb_en high once per 3 cycles.
- EXEC_PHASES=4, ifu_valid delayed 3 cycles -> exec_phase sequence 0,1,2,3; wb_en on cycle 4 after acceptance; inst holds ifu_inst value 0x00500093 throughout.
- WB with redirect_en=1, target 8000_0102 -> next ifu_addr 8000_0100. redirect_en pulsed during EXEC -> ignored, next addr pc+4.
- halt_req=1 in WB -> halted=1 next cycle and stays high; ifu_req stays 0 for 20 cycles; pc frozen at the updated value.
- rst asserted asynchronously mid-FETCH and mid-EXEC -> pc=8000_0000 and ifu_req=0 immediately; BOOT for 1 cycle after release, then FETCH.
- pc=FFFF_FFFC, no redirect -> next pc 0000_0000. With RETIRE_CNT_EN, 10 retired instructions -> retire_cnt=10; without it, retire_cnt=0.
